signed_accumulator_with_overflow: RTL



---
 rtl/signed_accumulator_with_overflow.sv | 97 +++++++++
 1 files changed

// File: rtl/signed_accumulator_with_overflow.sv
// Streaming signed accumulator: sums N_OPS operands per block and reports a sticky overflow flag.
// Define SIGNED_ACCUMULATOR_SATURATE_EN to clamp the running sum on overflow instead of wrapping.
module signed_accumulator_with_overflow #(
    parameter int WIDTH = 8,
    parameter int N_OPS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_overflow
);

    localparam int CNT_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_OPS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] sum;
    logic             step_ov;
    logic [WIDTH-1:0] next_acc;

    // Overflow only when both addends share a sign and the result's sign differs.
    always_comb begin
        sum     = acc + in_data;
        step_ov = (acc[WIDTH-1] == in_data[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
    end

`ifdef SIGNED_ACCUMULATOR_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // The overflow direction follows the sign of the (shared) addend sign.
    always_comb begin
        next_acc = sum;
        if (step_ov) begin
            next_acc = acc[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    always_comb begin
        next_acc = sum;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc <= next_acc;
                        ovf <= ovf | step_ov;
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= HOLD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        state <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

    assign in_ready     = (state == ACCUM);
    assign out_valid    = (state == HOLD);
    assign out_sum      = acc;
    assign out_overflow = ovf;

endmodule
